ref_reader_arbiter: RTL and testbench
=====================================

# ref_reader_arbiter

Shares one DRAM reference reader between `NUM_ENGINES` Smith-Waterman engines. Each engine posts a reference request (address, block count). The arbiter grants one request at a time, round-robin, and forwards it to the reader. It then steers the returned reference-sequence blocks to the granted engine until the requested count has been delivered. It sits between the engines' reference-reader ports and the single DRAM reference reader.

## Interface
- `NUM_ENGINES`, 4: number of requesting engines (2..16).
- `REF_LENGTH`, 256: bases per reference block; the block bus is `2*REF_LENGTH` bits.
- `GW`, 4: grant index width; must satisfy `2**GW >= NUM_ENGINES`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `eng_ref_addr_in`  in  `25*NUM_ENGINES`  per-engine DRAM start address; engine i occupies bits [25i+24:25i].
- `eng_ref_length_in`  in  `25*NUM_ENGINES`  per-engine block count, same packing.
- `eng_ref_info_valid_in`  in  `NUM_ENGINES`  request pending.
- `eng_ref_info_ack_out`  out  `NUM_ENGINES`  one-cycle request-accepted pulse.
- `eng_ref_seq_block_out`  out  `2*REF_LENGTH`  block data, broadcast to all engines.
- `eng_ref_seq_block_valid_out`  out  `NUM_ENGINES`  block valid, granted engine only.
- `eng_ref_seq_block_rdy_in`  in  `NUM_ENGINES`  engine accepts block.
- `ref_addr_out`  out  25  address to reader.
- `ref_length_out`  out  25  block count to reader.
- `ref_info_valid_out`  out  1  request to reader valid.
- `ref_info_rdy_in`  in  1  reader accepts request.
- `ref_seq_block_in`  in  `2*REF_LENGTH`  block from reader.
- `ref_seq_block_valid_in`  in  1  reader block valid.
- `ref_seq_block_rdy_out`  out  1  block accepted from reader.
- `grant_out`  out  `GW`  index of the engine currently being served.
- `busy_out`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, STREAM.
- **IDLE:**
  - If any `eng_ref_info_valid_in` bit is set, pick the first set bit at or after `rr_ptr`, wrapping around.
  - Latch that engine's addr and length into `cur_addr`/`cur_len`, latch the winner into `grant`, and set `rr_ptr <= grant+1` (mod `NUM_ENGINES`).
  - Next state is ISSUE, or IDLE if the latched length is 0.
  - Pulse `eng_ref_info_ack_out[grant]` in the following cycle in both cases. Zero-length requests never reach DRAM.
- **ISSUE:**
  - `ref_info_valid_out=1`, `ref_addr_out=cur_addr`, `ref_length_out=cur_len`.
  - On `ref_info_rdy_in`: clear `cnt` and go to STREAM.
- **STREAM:** combinational steering.
  - `ref_seq_block_rdy_out = eng_ref_seq_block_rdy_in[grant]`.
  - `eng_ref_seq_block_valid_out[grant] = ref_seq_block_valid_in`; all other valid bits are 0.
  - `eng_ref_seq_block_out = ref_seq_block_in` in every state.
  - Each handshake (valid & rdy) increments the 25-bit `cnt`.
  - The handshake with `cnt == cur_len-1` returns the FSM to IDLE.
- **Engine requirement:** an engine deasserts `eng_ref_info_valid_in` in the cycle after its ack. A request still asserted in IDLE is treated as new.
- **Outside STREAM:** `ref_seq_block_rdy_out=0`. Blocks arriving there are held off, not dropped.
- **Simultaneous requests:** only the winner is acked. The others stay pending and are granted on later IDLE visits in round-robin order.
- **New requests during ISSUE/STREAM:** ignored until IDLE.

## Timing
- **Reset values:**
  - All outputs 0.
  - `rr_ptr=0`, `grant=0`, `cnt=0`; state IDLE.
  - `eng_ref_seq_block_out` follows `ref_seq_block_in` combinationally, including during reset.
- **Reset mid-operation:** abandons the transfer immediately with no partial acks or valids. The reader shares `rst`.
- **Request latency:** valid sampled in IDLE at cycle T; ack and `ref_info_valid_out` are both high at T+1.
- **Throughput:** 1 block per cycle in STREAM; zero-cycle pass-through of valid and rdy.
- **Turnaround:** last block handshake at T gives IDLE at T+1; the next grant's ack is at T+2.
- **Registered outputs:** `busy_out` and `grant_out` are registered from state.

## Configuration
- **`REF_ARB_FIXED_PRIO_EN`**
  - Defined: fixed priority with the lowest index winning; `rr_ptr` is held at 0. Starvation is possible by design (debug/characterisation builds).
  - Undefined (default): round-robin as above.

## Test plan
- Single request: engine 2, addr `0x00100`, len 3, reader rdy immediate. Ack[2] at T+1 and `ref_info_valid_out` with addr `0x00100` / len 3 at T+1; exactly 3 blocks reach engine 2 only; IDLE follows.
- All 4 engines request at the same cycle, len 1 each. Grants occur in order 0,1,2,3 (round-robin). With `REF_ARB_FIXED_PRIO_EN` and engine 0 re-requesting immediately, engine 0 wins every time.
- Backpressure: len 4, toggle `eng_ref_seq_block_rdy_in[1]` every cycle. `ref_seq_block_rdy_out` mirrors it; `cnt` advances only on handshakes; exactly 4 blocks are delivered.
- Zero-length request from engine 3. Ack[3] pulses, `ref_info_valid_out` never rises, FSM is back in IDLE next cycle.
- Reader stalls `ref_info_rdy_in` low for 10 cycles. `ref_info_valid_out`, addr and len stay stable; no block valids reach any engine.
- Assert `rst` after the 2nd of 5 blocks. All outputs are 0 the next cycle, state IDLE, `rr_ptr` 0; a fresh request then completes normally.

Source files
------------

// File: rtl/ref_reader_arbiter.sv
// Round-robin arbiter sharing one DRAM reference reader between NUM_ENGINES engines.
// Optional macro REF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module ref_reader_arbiter #(
  parameter int NUM_ENGINES = 4,
  parameter int REF_LENGTH  = 256,
  parameter int GW          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [25*NUM_ENGINES-1:0]   eng_ref_addr_in,
  input  logic [25*NUM_ENGINES-1:0]   eng_ref_length_in,
  input  logic [NUM_ENGINES-1:0]      eng_ref_info_valid_in,
  output logic [NUM_ENGINES-1:0]      eng_ref_info_ack_out,
  output logic [2*REF_LENGTH-1:0]     eng_ref_seq_block_out,
  output logic [NUM_ENGINES-1:0]      eng_ref_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]      eng_ref_seq_block_rdy_in,
  output logic [24:0]                 ref_addr_out,
  output logic [24:0]                 ref_length_out,
  output logic                        ref_info_valid_out,
  input  logic                        ref_info_rdy_in,
  input  logic [2*REF_LENGTH-1:0]     ref_seq_block_in,
  input  logic                        ref_seq_block_valid_in,
  output logic                        ref_seq_block_rdy_out,
  output logic [GW-1:0]               grant_out,
  output logic                        busy_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  state_t                         state, state_nxt;
  logic [GW-1:0]                  grant, rr_ptr, pick, ptr_nxt;
  logic                           pick_vld;
  logic [NUM_ENGINES-1:0]         pick_oh, lane_rdy;
  logic [24:0]                    cur_addr, cur_len, cnt, sel_addr, sel_len;
  logic [NUM_ENGINES-1:0][24:0]   addr_a, len_a;
  logic                           streaming, hs, last;

  assign addr_a = eng_ref_addr_in;
  assign len_a  = eng_ref_length_in;

  // Two passes: lowest requester overall, then overridden by the lowest at/after rr_ptr.
  always_comb begin
    pick     = '0;
    pick_oh  = '0;
    sel_addr = '0;
    sel_len  = '0;
    pick_vld = |eng_ref_info_valid_in;
    for (int i = NUM_ENGINES-1; i >= 0; i--)
      if (eng_ref_info_valid_in[i]) pick = GW'(i);
    for (int i = NUM_ENGINES-1; i >= 0; i--)
      if (eng_ref_info_valid_in[i] && (GW'(i) >= rr_ptr)) pick = GW'(i);
    for (int i = 0; i < NUM_ENGINES; i++)
      if (GW'(i) == pick) begin
        pick_oh[i] = pick_vld;
        sel_addr   = addr_a[i];
        sel_len    = len_a[i];
      end
  end

`ifdef REF_ARB_FIXED_PRIO_EN
  assign ptr_nxt = '0;
`else
  assign ptr_nxt = (pick == GW'(NUM_ENGINES-1)) ? '0 : pick + 1'b1;
`endif

  assign streaming = (state == STREAM);

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_lane
    assign eng_ref_seq_block_valid_out[i] = streaming && (grant == GW'(i)) && ref_seq_block_valid_in;
    assign lane_rdy[i] = (grant == GW'(i)) && eng_ref_seq_block_rdy_in[i];
  end

  assign ref_seq_block_rdy_out = streaming && (|lane_rdy);
  assign eng_ref_seq_block_out = ref_seq_block_in;
  assign hs   = ref_seq_block_valid_in && ref_seq_block_rdy_out;
  assign last = (cnt == cur_len - 25'd1);

  assign ref_info_valid_out = (state == ISSUE);
  assign ref_addr_out       = (state == ISSUE) ? cur_addr : '0;
  assign ref_length_out     = (state == ISSUE) ? cur_len  : '0;
  assign grant_out          = grant;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_vld && (sel_len != '0)) state_nxt = ISSUE;
      ISSUE:   if (ref_info_rdy_in) state_nxt = STREAM;
      STREAM:  if (hs && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      grant                <= '0;
      rr_ptr               <= '0;
      cur_addr             <= '0;
      cur_len              <= '0;
      cnt                  <= '0;
      eng_ref_info_ack_out <= '0;
      busy_out             <= 1'b0;
    end else begin
      state                <= state_nxt;
      busy_out             <= (state_nxt != IDLE);
      eng_ref_info_ack_out <= '0;
      unique case (state)
        IDLE: if (pick_vld) begin
          grant                <= pick;
          cur_addr             <= sel_addr;
          cur_len              <= sel_len;
          rr_ptr               <= ptr_nxt;
          eng_ref_info_ack_out <= pick_oh;
        end
        ISSUE:   if (ref_info_rdy_in) cnt <= '0;
        STREAM:  if (hs) cnt <= cnt + 25'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_reader_arbiter.sv
// Scoreboard bench for ref_reader_arbiter: bench acts as engines and DRAM reader.
module tb_ref_reader_arbiter;
  localparam int N = 4, RL = 256, GW = 4;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [N-1:0][24:0] eaddr, elen;
  logic [N-1:0]       evld, eack, ebvld, erdy;
  logic [2*RL-1:0]    eblk, rblk;
  logic [24:0]        raddr, rlen;
  logic               rivld, rirdy, rbvld, rbrdy, busy;
  logic [GW-1:0]      gnt;

  int total = 0, bad = 0, rr_model = 0;
  logic [2*RL-1:0] exp_q[$];

  ref_reader_arbiter #(.NUM_ENGINES(N), .REF_LENGTH(RL), .GW(GW)) dut (
    .clk(clk), .rst(rst),
    .eng_ref_addr_in(eaddr), .eng_ref_length_in(elen),
    .eng_ref_info_valid_in(evld), .eng_ref_info_ack_out(eack),
    .eng_ref_seq_block_out(eblk), .eng_ref_seq_block_valid_out(ebvld),
    .eng_ref_seq_block_rdy_in(erdy),
    .ref_addr_out(raddr), .ref_length_out(rlen),
    .ref_info_valid_out(rivld), .ref_info_rdy_in(rirdy),
    .ref_seq_block_in(rblk), .ref_seq_block_valid_in(rbvld),
    .ref_seq_block_rdy_out(rbrdy), .grant_out(gnt), .busy_out(busy)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int e);
    logic [N-1:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first pending at/after rr_model, wrapping.
  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(rr_model + k) % N]) return (rr_model + k) % N;
    return 0;
  endfunction

  task automatic rand_blk(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
  endtask

  task automatic stream(input int e, input bit toggle, input int stop);
    int got = 0, guard = 0;
    bit pend = 1'b0;
    logic [511:0] d;
    while (got < stop && guard < 200) begin
      if (!pend) begin
        rand_blk(d);
        rblk = d;
        exp_q.push_back(d);
      end
      rbvld = 1'b1;
      erdy = '0;
      erdy[e] = toggle ? (guard % 2 == 1) : 1'b1;
      #1;
      chk("rdy_mirror", rbrdy, erdy[e]);
      chk("blk_vld_steer", ebvld, onehot(e));
      chk("blk_bcast", eblk, rblk);
      if (ebvld[e] && erdy[e]) begin
        chk("blk_data", eblk, exp_q.pop_front());
        got++;
        pend = 1'b0;
      end else pend = 1'b1;
      @(negedge clk);
      guard++;
    end
    chk("blk_count", got, stop);
    exp_q.delete();
    rbvld = 1'b0;
    erdy = '0;
  endtask

  // Expects pending request(s) to be sampled at the next rising edge.
  task automatic serve(input int stall, input bit toggle, input int stop);
    int e;
    logic [24:0] a, l;
    e = model_pick(evld);
`ifdef REF_ARB_FIXED_PRIO_EN
    rr_model = 0;
`else
    rr_model = (e + 1) % N;
`endif
    a = eaddr[e];
    l = elen[e];
    @(negedge clk); #1;
    chk("ack", eack, onehot(e));
    chk("grant", gnt, e);
    evld[e] = 1'b0;
    if (l == 0) begin
      chk("zl_no_issue", rivld, 0);
      chk("zl_idle", busy, 0);
      @(negedge clk); #1;
      chk("zl_ack_once", eack, 0);
      chk("zl_still_no_issue", rivld, 0);
      return;
    end
    chk("issue_vld", rivld, 1);
    chk("issue_addr", raddr, a);
    chk("issue_len", rlen, l);
    chk("busy", busy, 1);
    rbvld = 1'b1;
    erdy = '1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      chk("stall_vld", rivld, 1);
      chk("stall_addr", raddr, a);
      chk("stall_len", rlen, l);
      chk("stall_no_blk", ebvld, 0);
      chk("stall_rdy_out", rbrdy, 0);
      chk("stall_no_ack", eack, 0);
    end
    rbvld = 1'b0;
    erdy = '0;
    rirdy = 1'b1;
    @(negedge clk);
    rirdy = 1'b0;
    stream(e, toggle, stop);
    if (stop == int'(l)) begin
      #1;
      chk("back_idle", busy, 0);
      chk("idle_no_issue", rivld, 0);
      rbvld = 1'b1;
      erdy = '1;
      #1;
      chk("held_off_vld", ebvld, 0);
      chk("held_off_rdy", rbrdy, 0);
      rbvld = 1'b0;
      erdy = '0;
    end
  endtask

  task automatic req(input int e, input logic [24:0] a, input logic [24:0] l);
    eaddr[e] = a;
    elen[e]  = l;
    evld[e]  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] d;
    rst = 1'b1; eaddr = '0; elen = '0; evld = '1; erdy = '1;
    rirdy = 1'b0; rbvld = 1'b1;
    rand_blk(d);
    rblk = d;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", eack, 0);
    chk("rst_bvld", ebvld, 0);
    chk("rst_ivld", rivld, 0);
    chk("rst_addr", raddr, 0);
    chk("rst_len", rlen, 0);
    chk("rst_rdy", rbrdy, 0);
    chk("rst_grant", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcast", eblk, d);
    evld = '0; erdy = '0; rbvld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;

    req(2, 25'h00100, 25'd3);  serve(0, 1'b0, 3);   // single request
    req(1, 25'h0ABCD, 25'd4);  serve(0, 1'b1, 4);   // backpressure
    req(3, 25'h01234, 25'd0);  serve(0, 1'b0, 0);   // zero length
    req(0, 25'h1F00F, 25'd2);  serve(10, 1'b0, 2);  // reader stall

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
    for (int i = 0; i < N; i++) req(i, 25'(32'h200 + i), 25'd1);
    for (int i = 0; i < N; i++) serve(0, 1'b0, 1);  // simultaneous
`ifdef REF_ARB_FIXED_PRIO_EN
    for (int r = 0; r < 3; r++) begin
      req(0, 25'h00300, 25'd1);
      req(2, 25'h00302, 25'd1);
      serve(0, 1'b0, 1);
    end
    evld = '0;
`endif

    req(1, 25'h00777, 25'd5);
    serve(0, 1'b0, 2);   // stop after 2 of 5 blocks
    rbvld = 1'b1; erdy = '1; rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_bvld", ebvld, 0);
    chk("mid_rst_rdy", rbrdy, 0);
    chk("mid_rst_ivld", rivld, 0);
    chk("mid_rst_ack", eack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", gnt, 0);
    rst = 1'b0; rbvld = 1'b0; erdy = '0;
    rr_model = 0;
    // rr_ptr back at 0 means engine 1 wins over engine 3
    req(1, 25'h00900, 25'd2);
    req(3, 25'h00903, 25'd1);
    serve(0, 1'b0, 2);
    serve(0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
